// File: rtl/lsm_pv_accumulator.sv
// lsm_pv_accumulator: accumulates per-path PVs over a batch and emits mean and population variance.
module lsm_pv_accumulator #(
  parameter int WIDTH      = 32,
  parameter int QINT       = 15,
  parameter int QFRAC      = WIDTH - 1 - QINT,
  parameter int LOG2_PATHS = 10
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    valid_in,
  input  logic signed [WIDTH-1:0] PV,
  output logic                    in_ready,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] mean_pv,
  output logic signed [WIDTH-1:0] var_pv,
  output logic                    sat_flag,
  output logic                    drop_err
);
  localparam int SW = WIDTH + LOG2_PATHS;
  localparam int QW = 2*WIDTH + LOG2_PATHS;
  localparam logic [LOG2_PATHS:0] NUM = (LOG2_PATHS+1)'(1) << LOG2_PATHS;
  localparam logic signed [QW-1:0] MAXV = {{(QW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [QW-1:0] MINV = ~MAXV;

  typedef enum logic [2:0] {IDLE, ACCUM, CALC1, CALC2, DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [SW-1:0]     acc_sum_q, acc_sum_d;
  logic signed [QW-1:0]     acc_sq_q, acc_sq_d;
  logic [LOG2_PATHS:0]      cnt_q, cnt_d;
  logic signed [WIDTH-1:0]  mean_q, mean_d, msq_q, msq_d, var_q, var_d;
  logic                     sat_q, sat_d, drop_q, drop_d, ov_q, ov_d;

  // Returns {clamped, value}; every intermediate fits in the widest accumulator width.
  function automatic logic [WIDTH:0] sat_w(input logic signed [QW-1:0] x);
    sat_w = (x > MAXV) ? {1'b1, MAXV[WIDTH-1:0]} :
            (x < MINV) ? {1'b1, MINV[WIDTH-1:0]} : {1'b0, x[WIDTH-1:0]};
  endfunction

  logic signed [2*WIDTH-1:0] pp, mm;
  logic signed [SW-1:0]      sum_sh;
  logic signed [QW-1:0]      sq_sh;
  logic [WIDTH:0]            m_sat, q_sat, m2_sat;
  logic signed [WIDTH-1:0]   m2_v;
  logic signed [WIDTH:0]     diff;

  assign pp     = (2*WIDTH)'(PV) * (2*WIDTH)'(PV);
  assign mm     = (2*WIDTH)'(mean_q) * (2*WIDTH)'(mean_q);
  assign sum_sh = acc_sum_q >>> LOG2_PATHS;
  assign sq_sh  = acc_sq_q >>> (LOG2_PATHS + QFRAC);
  assign m_sat  = sat_w(QW'(sum_sh));
  assign q_sat  = sat_w(sq_sh);
  assign m2_sat = sat_w(QW'(mm >>> QFRAC));
  assign m2_v   = $signed(m2_sat[WIDTH-1:0]);
  assign diff   = (WIDTH+1)'(msq_q) - (WIDTH+1)'(m2_v);

  always_comb begin
    state_d   = state_q;
    acc_sum_d = acc_sum_q;
    acc_sq_d  = acc_sq_q;
    cnt_d     = cnt_q;
    mean_d    = mean_q;
    msq_d     = msq_q;
    var_d     = var_q;
    sat_d     = sat_q;
    ov_d      = ov_q;
    drop_d    = drop_q | (valid_in && state_q != ACCUM);
    case (state_q)
      IDLE: if (start) begin
        state_d   = ACCUM;
        acc_sum_d = '0;
        acc_sq_d  = '0;
        cnt_d     = '0;
        sat_d     = 1'b0;
        drop_d    = valid_in;
      end
      ACCUM: if (valid_in) begin
        acc_sum_d = acc_sum_q + SW'(PV);
        acc_sq_d  = acc_sq_q + QW'(pp);
        cnt_d     = cnt_q + 1'b1;
        state_d   = (cnt_d == NUM) ? CALC1 : ACCUM;
      end
      CALC1: begin
        mean_d  = m_sat[WIDTH-1:0];
        msq_d   = q_sat[WIDTH-1:0];
        sat_d   = sat_q | m_sat[WIDTH] | q_sat[WIDTH];
        state_d = CALC2;
      end
      CALC2: begin
        var_d   = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
        sat_d   = sat_q | m2_sat[WIDTH];
        ov_d    = 1'b1;
        state_d = DONE;
      end
      DONE: if (out_ready) begin
        ov_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_sum_q <= '0;
      acc_sq_q  <= '0;
      cnt_q     <= '0;
      mean_q    <= '0;
      msq_q     <= '0;
      var_q     <= '0;
      sat_q     <= 1'b0;
      drop_q    <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_sum_q <= acc_sum_d;
      acc_sq_q  <= acc_sq_d;
      cnt_q     <= cnt_d;
      mean_q    <= mean_d;
      msq_q     <= msq_d;
      var_q     <= var_d;
      sat_q     <= sat_d;
      drop_q    <= drop_d;
      ov_q      <= ov_d;
    end
  end

  assign in_ready  = state_q == ACCUM;
  assign busy      = state_q != IDLE;
  assign out_valid = ov_q;
  assign mean_pv   = mean_q;
  assign var_pv    = var_q;
  assign sat_flag  = sat_q;
  assign drop_err  = drop_q;
endmodule

// File: tb/tb_lsm_pv_accumulator.sv
// tb_lsm_pv_accumulator: scoreboard bench; a plain-arithmetic model predicts each batch result.
module tb_lsm_pv_accumulator;
  localparam int W = 32, L = 2, NP = 4;
  localparam logic signed [127:0] MAXV = 128'sd2147483647;
  localparam logic signed [127:0] MINV = -128'sd2147483648;

  typedef struct packed {logic [W-1:0] mean; logic [W-1:0] vr; logic sat;} res_t;
  typedef logic signed [W-1:0] batch_t [NP];

  logic clk, rst, start, valid_in, out_ready;
  logic signed [W-1:0] pv, mean_pv, var_pv;
  logic in_ready, busy, out_valid, sat_flag, drop_err;
  res_t exp_q[$];
  res_t last;
  int n_tests = 0, n_fail = 0;

  lsm_pv_accumulator #(.WIDTH(W), .QINT(15), .QFRAC(16), .LOG2_PATHS(L)) dut (
    .clk(clk), .rst(rst), .start(start), .valid_in(valid_in), .PV(pv),
    .in_ready(in_ready), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .mean_pv(mean_pv), .var_pv(var_pv), .sat_flag(sat_flag), .drop_err(drop_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic signed [127:0] fdiv(input logic signed [127:0] a, input logic signed [127:0] b);
    fdiv = a / b;
    if ((a % b) != 0 && a < 0) fdiv = fdiv - 1;
  endfunction

  function automatic bit oob(input logic signed [127:0] x);
    return x > MAXV || x < MINV;
  endfunction

  function automatic logic signed [127:0] clamp(input logic signed [127:0] x);
    return x > MAXV ? MAXV : x < MINV ? MINV : x;
  endfunction

  // Mean = floor(sum/N); variance = E[x^2] - mean^2, each term clamped to the word range.
  function automatic res_t model(input batch_t b);
    logic signed [127:0] s, sq, m, msq, m2, d;
    bit f;
    s = 0; sq = 0; f = 0;
    foreach (b[i]) begin
      s  = s + 128'(b[i]);
      sq = sq + 128'(b[i]) * 128'(b[i]);
    end
    m   = fdiv(s, NP);
    f   = f | oob(m);
    m   = clamp(m);
    msq = fdiv(sq, NP * 65536);
    f   = f | oob(msq);
    msq = clamp(msq);
    m2  = fdiv(m * m, 65536);
    f   = f | oob(m2);
    m2  = clamp(m2);
    d   = msq - m2;
    if (d < 0) d = 0;
    model.mean = m[W-1:0];
    model.vr   = d[W-1:0];
    model.sat  = f;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got mean %h with no batch outstanding", mean_pv);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("mean_pv", mean_pv, e.mean);
        check("var_pv", var_pv, e.vr);
        check("sat_flag", W'(sat_flag), W'(e.sat));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_batch(input batch_t b, input int max_gap, input bit chk_lat);
    start = 1;
    tick;
    start = 0;
    check("in_ready_after_start", W'(in_ready), 1);
    check("drop_err_cleared_by_start", W'(drop_err), 0);
    last = model(b);
    exp_q.push_back(last);
    for (int i = 0; i < NP; i++) begin
      repeat ($urandom_range(0, max_gap)) tick;
      valid_in = 1;
      pv = b[i];
      tick;
      valid_in = 0;
    end
    if (chk_lat) begin
      check("lat_edge0", W'(out_valid), 0);
      tick;
      check("lat_edge1", W'(out_valid), 0);
      tick;
      check("lat_edge2", W'(out_valid), 1);
    end
  endtask

  task automatic wait_idle(input bit rand_ready);
    int k;
    k = 0;
    while (busy && k < 60) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick;
      k++;
    end
    out_ready = 1;
    check("batch_completes", W'(busy), 0);
  endtask

  initial begin
    batch_t c1, c2, c6, rb;
    logic signed [W-1:0] tmp;
    int k;
    c1 = '{32'sh10000, 32'sh20000, 32'sh30000, 32'sh40000};
    c2 = '{-32'sh10000, 32'sh10000, -32'sh10000, 32'sh10000};
    c6 = '{32'sh7FFF0000, 32'sh7FFF0000, 32'sh7FFF0000, 32'sh7FFF0000};
    rst = 1; start = 0; valid_in = 0; pv = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), 0);
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_in_ready", W'(in_ready), 0);
    check("rst_mean", mean_pv, 0);
    check("rst_var", var_pv, 0);
    check("rst_drop", W'(drop_err), 0);
    rst = 0;
    tick;
    run_batch(c1, 0, 1);
    wait_idle(0);
    run_batch(c2, 3, 0);
    wait_idle(0);
    valid_in = 1;
    pv = 32'sh50000;
    tick;
    valid_in = 0;
    check("idle_valid_drop_err", W'(drop_err), 1);
    check("idle_valid_no_state_change", W'(busy), 0);
    run_batch(c1, 0, 0);
    wait_idle(0);
    out_ready = 0;
    for (int i = 0; i < NP; i++) rb[i] = $urandom;
    run_batch(rb, 1, 0);
    k = 0;
    while (!out_valid && k < 20) begin
      tick;
      k++;
    end
    check("done_reached", W'(out_valid), 1);
    for (int c = 0; c < 5; c++) begin
      start = c == 1;
      valid_in = c == 3;
      pv = $urandom;
      tick;
      start = 0;
      valid_in = 0;
      check("done_hold_valid", W'(out_valid), 1);
      check("done_hold_busy", W'(busy), 1);
      check("done_hold_mean", mean_pv, last.mean);
      check("done_hold_var", var_pv, last.vr);
    end
    check("done_valid_drop_err", W'(drop_err), 1);
    out_ready = 1;
    start = 1;
    tick;
    start = 0;
    check("handoff_out_valid", W'(out_valid), 0);
    check("handoff_start_ignored", W'(busy), 0);
    start = 1;
    tick;
    start = 0;
    valid_in = 1;
    pv = 32'sh10000;
    tick;
    pv = 32'sh20000;
    tick;
    valid_in = 0;
    rst = 1;
    #1;
    check("midrst_busy", W'(busy), 0);
    check("midrst_in_ready", W'(in_ready), 0);
    check("midrst_out_valid", W'(out_valid), 0);
    check("midrst_mean", mean_pv, 0);
    check("midrst_var", var_pv, 0);
    check("midrst_sat", W'(sat_flag), 0);
    check("midrst_drop", W'(drop_err), 0);
    tick;
    rst = 0;
    tick;
    run_batch(c1, 0, 0);
    wait_idle(0);
    run_batch(c6, 0, 0);
    wait_idle(0);
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NP; i++) begin
        if (n % 2 == 0) tmp = $urandom;
        else begin
          tmp = $urandom_range(0, 2097152);
          tmp = tmp - 32'sd1048576;
        end
        rb[i] = tmp;
      end
      run_batch(rb, 2, 0);
      wait_idle(1);
    end
    repeat (3) tick;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
